// File: rtl/riscv_lsu_pkg.sv
// Shared constants and types for the RISC-V load/store unit.
// Holds funct3 encodings, byte-enable masks and the FSM state encoding.
package riscv_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load extraction with sign/zero extension, and access legality.
module lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misalign,
   output logic        illegal
);

   logic [31:0] lane;

   // Shift the addressed lane down to bit 0 before extension.
   assign lane = rdata >> {off, 3'b000};

   always_comb begin
      be        = '0;
      wdata_rep = wdata;
      rdata_ext = '0;
      misalign  = 1'b0;
      illegal   = 1'b0;
      case (funct3)
         F3_B: begin
            be        = BE_B << off;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{lane[7]}}, lane[7:0]};
         end
         F3_BU: begin
            be        = BE_B << off;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {24'h0, lane[7:0]};
         end
         F3_H: begin
            be        = BE_H << off;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{lane[15]}}, lane[15:0]};
            misalign  = off[0];
         end
         F3_HU: begin
            be        = BE_H << off;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {16'h0, lane[15:0]};
            misalign  = off[0];
         end
         F3_W: begin
            be        = BE_W;
            rdata_ext = rdata;
            misalign  = (off != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: latches a core access, runs a req/gnt/rvalid memory
// handshake with timeout, stalls the core and reports a one-cycle completion.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rset,
   input  logic              lsu_valid,
   input  logic              lsu_we,
   input  logic [2:0]        lsu_funct3,
   input  logic [31:0]       lsu_addr,
   input  logic [31:0]       lsu_wdata,
   output logic              lsu_stall,
   output logic              lsu_done,
   output logic              lsu_err,
   output logic [31:0]       lsu_rdata,
   output logic              MEM_req,
   output logic              MEM_we,
   output logic [ADDR_W-1:0] MEM_addr,
   output logic [3:0]        MEM_be,
   output logic [31:0]       MEM_wDATA,
   input  logic              MEM_gnt,
   input  logic              MEM_rvalid,
   input  logic [31:0]       MEM_rData,
   output lsu_state_e        dbg_state
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   lsu_state_e          state, state_n;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                err_q, err_n;
   logic [31:0]         rdata_q, rdata_n;
   logic [CNT_W-1:0]    cnt, cnt_n;

   logic                in_idle, in_req, in_resp, in_done;
   logic [2:0]          a_f3;
   logic [1:0]          a_off;
   logic [3:0]          a_be;
   logic [31:0]         a_wdata_rep, a_rdata_ext;
   logic                a_misalign, a_illegal;
   logic                bad, to_hit;
   logic                addr_unused;

   assign addr_unused = ^lsu_addr[31:ADDR_W+2];

   assign in_idle = (state == S_IDLE);
   assign in_req  = (state == S_REQ);
   assign in_resp = (state == S_RESP);
   assign in_done = (state == S_DONE);

   // In IDLE the lane logic judges the live request; afterwards it works on the latched one.
   assign a_f3  = in_idle ? lsu_funct3    : f3_q;
   assign a_off = in_idle ? lsu_addr[1:0] : addr_q[1:0];

   lsu_align u_align (
      .funct3    (a_f3),
      .off       (a_off),
      .wdata     (wdata_q),
      .rdata     (MEM_rData),
      .be        (a_be),
      .wdata_rep (a_wdata_rep),
      .rdata_ext (a_rdata_ext),
      .misalign  (a_misalign),
      .illegal   (a_illegal)
   );

   assign bad    = a_misalign | a_illegal | (lsu_we & lsu_funct3[2]);
   assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

   // Memory handshake: MEM_req with stable fields until the cycle MEM_gnt is high;
   // read data is taken on MEM_rvalid from the cycle after the grant onwards.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = err_q;
      rdata_n = rdata_q;
      case (state)
         S_IDLE: begin
            if (lsu_valid) begin
               cnt_n   = '0;
               rdata_n = '0;
               err_n   = bad;
               state_n = bad ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (MEM_gnt) begin
               cnt_n   = '0;
               state_n = we_q ? S_DONE : S_RESP;
            end else if (to_hit) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_RESP: begin
            if (MEM_rvalid) begin
               rdata_n = a_rdata_ext;
               state_n = S_DONE;
            end else if (to_hit) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rset) begin
      if (!rset) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         err_q   <= err_n;
         rdata_q <= rdata_n;
         if (in_idle && lsu_valid) begin
            we_q    <= lsu_we;
            f3_q    <= lsu_funct3;
            addr_q  <= lsu_addr[ADDR_W+1:0];
            wdata_q <= lsu_wdata;
         end
      end
   end

   // Reset gates the one input-driven output so everything reads 0 under rset.
   assign lsu_stall = rset & ((in_idle & lsu_valid) | in_req | in_resp);
   assign lsu_done  = in_done;
   assign lsu_err   = in_done & err_q;
   assign lsu_rdata = in_done ? rdata_q : '0;
   assign MEM_req   = in_req;
   assign MEM_we    = in_req & we_q;
   assign MEM_addr  = in_req ? addr_q[ADDR_W+1:2] : '0;
   assign MEM_be    = in_req ? a_be : '0;
   assign MEM_wDATA = (in_req & we_q) ? a_wdata_rep : '0;
   assign dbg_state = state;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: stores, sub-word loads, illegal/misaligned
// accesses, grant timeout and asynchronous reset mid-transaction.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   logic        clk;
   logic        rset;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_stall;
   logic        lsu_done;
   logic        lsu_err;
   logic [31:0] lsu_rdata;
   logic        MEM_req;
   logic        MEM_we;
   logic [7:0]  MEM_addr;
   logic [3:0]  MEM_be;
   logic [31:0] MEM_wDATA;
   logic        MEM_gnt;
   logic        MEM_rvalid;
   logic [31:0] MEM_rData;
   lsu_state_e  dbg_state;

   int checks = 0;
   int errors = 0;

   // results of the last run_op
   logic        got_done, r_err, stable, m_we, idle_stall;
   logic [31:0] r_rdata, m_wdata;
   logic [7:0]  m_addr;
   logic [3:0]  m_be;
   int          r_cyc, req_seen;

   riscv_lsu #(.ADDR_W(8), .TIMEOUT(15), .CNT_W(4)) dut (
      .clk        (clk),
      .rset       (rset),
      .lsu_valid  (lsu_valid),
      .lsu_we     (lsu_we),
      .lsu_funct3 (lsu_funct3),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_stall  (lsu_stall),
      .lsu_done   (lsu_done),
      .lsu_err    (lsu_err),
      .lsu_rdata  (lsu_rdata),
      .MEM_req    (MEM_req),
      .MEM_we     (MEM_we),
      .MEM_addr   (MEM_addr),
      .MEM_be     (MEM_be),
      .MEM_wDATA  (MEM_wDATA),
      .MEM_gnt    (MEM_gnt),
      .MEM_rvalid (MEM_rvalid),
      .MEM_rData  (MEM_rData),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one access in IDLE, then play memory: grant after gnt_wait REQ cycles,
   // rvalid rv_wait cycles after the cycle following the grant. Ends back in IDLE.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_wait, input int rv_wait,
                         input logic [31:0] rword);
      int   after;
      logic granted;
      got_done = 0; r_err = 0; r_rdata = 0; r_cyc = 0; req_seen = 0; stable = 1;
      m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
      granted = 0; after = 0;
      lsu_valid = 1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
      #1 idle_stall = lsu_stall;
      @(posedge clk); #1;
      lsu_valid = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
      for (int c = 0; c < 40; c++) begin
         MEM_gnt = 0; MEM_rvalid = 0; MEM_rData = 0;
         #1;
         if (lsu_done) begin
            got_done = 1; r_err = lsu_err; r_rdata = lsu_rdata; r_cyc = c + 2;
            break;
         end
         if (granted) begin
            if (after == rv_wait) begin
               MEM_rvalid = 1; MEM_rData = rword;
            end
            after++;
         end
         if (MEM_req) begin
            if (req_seen == 0) begin
               m_we = MEM_we; m_addr = MEM_addr; m_be = MEM_be; m_wdata = MEM_wDATA;
            end else if (m_we !== MEM_we || m_addr !== MEM_addr || m_be !== MEM_be ||
                         m_wdata !== MEM_wDATA) begin
               stable = 0;
            end
            if (req_seen == gnt_wait) begin
               MEM_gnt = 1; granted = 1;
               if (!we) begin
                  MEM_rvalid = 1; MEM_rData = 32'hBAD0_BAD0;
               end
            end
            req_seen++;
         end
         @(posedge clk); #1;
      end
      MEM_gnt = 0; MEM_rvalid = 0; MEM_rData = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      rset = 0; lsu_valid = 1; lsu_we = 1; lsu_funct3 = F3_W; lsu_addr = 32'h10;
      lsu_wdata = 32'hFFFF_FFFF; MEM_gnt = 0; MEM_rvalid = 0; MEM_rData = 0;
      #23;
      check("rst_stall", {31'b0, lsu_stall}, 0);
      check("rst_done", {31'b0, lsu_done}, 0);
      check("rst_req", {31'b0, MEM_req}, 0);
      check("rst_be", {28'b0, MEM_be}, 0);
      check("rst_wdata", MEM_wDATA, 0);
      check("rst_rdata", lsu_rdata, 0);
      lsu_valid = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
      @(posedge clk); #3 rset = 1;
      @(posedge clk); #1;

      // SW, immediate grant
      run_op(1, F3_W, 32'h10, 32'hDEADBEEF, 0, 0, 0);
      check("sw_idle_stall", {31'b0, idle_stall}, 1);
      check("sw_addr", {24'b0, m_addr}, 32'h04);
      check("sw_be", {28'b0, m_be}, 32'hF);
      check("sw_wdata", m_wdata, 32'hDEADBEEF);
      check("sw_we", {31'b0, m_we}, 1);
      check("sw_done", {31'b0, got_done}, 1);
      check("sw_cyc", r_cyc, 3);
      check("sw_err", {31'b0, r_err}, 0);
      check("sw_rdata", r_rdata, 0);

      // SB to lane 3
      run_op(1, F3_B, 32'h13, 32'h0000_00A5, 0, 0, 0);
      check("sb_be", {28'b0, m_be}, 32'h8);
      check("sb_wdata", m_wdata, 32'hA5A5A5A5);
      check("sb_addr", {24'b0, m_addr}, 32'h04);

      // SH to upper half, grant after 2 waiting cycles
      run_op(1, F3_H, 32'h2, 32'h0000_1234, 2, 0, 0);
      check("sh_be", {28'b0, m_be}, 32'hC);
      check("sh_wdata", m_wdata, 32'h12341234);
      check("sh_stable", {31'b0, stable}, 1);
      check("sh_cyc", r_cyc, 5);
      check("sh_err", {31'b0, r_err}, 0);

      // sub-word loads (rvalid in the grant cycle carries junk and must be ignored)
      run_op(0, F3_B, 32'h11, 0, 0, 0, 32'h0000_8000);
      check("lb_rdata", r_rdata, 32'hFFFFFF80);
      check("lb_cyc", r_cyc, 4);
      check("lb_we", {31'b0, m_we}, 0);
      check("lb_addr", {24'b0, m_addr}, 32'h04);
      check("lb_be", {28'b0, m_be}, 32'h2);
      run_op(0, F3_BU, 32'h11, 0, 0, 0, 32'h0000_8000);
      check("lbu_rdata", r_rdata, 32'h00000080);
      run_op(0, F3_H, 32'h12, 0, 0, 0, 32'h8001_0000);
      check("lh_rdata", r_rdata, 32'hFFFF8001);
      run_op(0, F3_HU, 32'h12, 0, 0, 0, 32'h8001_0000);
      check("lhu_rdata", r_rdata, 32'h00008001);
      run_op(0, F3_W, 32'h20, 0, 1, 3, 32'h1357_9BDF);
      check("lw_rdata", r_rdata, 32'h13579BDF);
      check("lw_cyc", r_cyc, 8);
      check("lw_err", {31'b0, r_err}, 0);

      // misaligned and illegal: no memory access, DONE next cycle
      run_op(0, F3_W, 32'h06, 0, 0, 0, 32'h1111_1111);
      check("lw_mis_req", req_seen, 0);
      check("lw_mis_cyc", r_cyc, 2);
      check("lw_mis_err", {31'b0, r_err}, 1);
      check("lw_mis_rdata", r_rdata, 0);
      run_op(0, 3'b111, 32'h10, 0, 0, 0, 32'h1111_1111);
      check("f3_111_req", req_seen, 0);
      check("f3_111_err", {31'b0, r_err}, 1);
      run_op(1, F3_H, 32'h01, 32'hFFFF, 0, 0, 0);
      check("sh_mis_err", {31'b0, r_err}, 1);
      check("sh_mis_req", req_seen, 0);
      run_op(1, F3_BU, 32'h10, 32'hFF, 0, 0, 0);
      check("sbu_ill_err", {31'b0, r_err}, 1);
      check("sbu_ill_req", req_seen, 0);

      // grant never comes: timeout after 15 request cycles
      run_op(0, F3_W, 32'h40, 0, 99, 0, 0);
      check("to_req_cycles", req_seen, 15);
      check("to_done", {31'b0, got_done}, 1);
      check("to_err", {31'b0, r_err}, 1);
      check("to_cyc", r_cyc, 17);
      check("to_rdata", r_rdata, 0);
      MEM_rvalid = 1; MEM_rData = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      MEM_rvalid = 0; MEM_rData = 0;
      check("late_rv_state", 32'(dbg_state), 32'(S_IDLE));
      check("late_rv_done", {31'b0, lsu_done}, 0);

      // async reset while in REQ drops MEM_req without a clock edge
      lsu_valid = 1; lsu_we = 1; lsu_funct3 = F3_W; lsu_addr = 32'h30; lsu_wdata = 32'h5;
      @(posedge clk); #1;
      lsu_valid = 0;
      check("req_pre_rst", {31'b0, MEM_req}, 1);
      #2 rset = 0;
      #1;
      check("req_rst_req", {31'b0, MEM_req}, 0);
      check("req_rst_wdata", MEM_wDATA, 0);
      check("req_rst_stall", {31'b0, lsu_stall}, 0);
      @(posedge clk); #3 rset = 1;
      @(posedge clk); #1;

      // async reset while in RESP
      lsu_valid = 1; lsu_we = 0; lsu_funct3 = F3_W; lsu_addr = 32'h20;
      @(posedge clk); #1;
      lsu_valid = 0; MEM_gnt = 1;
      @(posedge clk); #1;
      MEM_gnt = 0;
      check("resp_stall", {31'b0, lsu_stall}, 1);
      check("resp_state", 32'(dbg_state), 32'(S_RESP));
      #2 rset = 0;
      #1;
      check("resp_rst_stall", {31'b0, lsu_stall}, 0);
      check("resp_rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("resp_rst_done", {31'b0, lsu_done}, 0);
      @(posedge clk); #3 rset = 1;
      @(posedge clk); #1;

      run_op(1, F3_W, 32'h24, 32'hCAFEF00D, 0, 0, 0);
      check("post_sw_addr", {24'b0, m_addr}, 32'h09);
      check("post_sw_wdata", m_wdata, 32'hCAFEF00D);
      check("post_sw_cyc", r_cyc, 3);
      check("post_sw_err", {31'b0, r_err}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit between the RISC-V core datapath and data memory. It replaces the fixed single-cycle 8-bit-address MEM_addr/MEM_wDATA/dm_we path with a request/grant/response handshake. It adds sub-word access (byte and half), sign/zero extension, misalignment detection, core stall generation and a response timeout.

Parameters:
ADDR_W, 8, width of MEM_addr (word address); byte address bits used are lsu_addr[ADDR_W+1:2]
TIMEOUT, 15, maximum cycles waiting in REQ or RESP before error completion; 0 disables the timeout
CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rset  in  1  asynchronous, active-low reset
lsu_valid  in  1  core presents a load/store this cycle
lsu_we  in  1  1 = store, 0 = load
lsu_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr  in  32  byte address (ALU result)
lsu_wdata  in  32  store data (rs2)
lsu_stall  out  1  freeze PC/register file while high
lsu_done  out  1  one-cycle completion pulse
lsu_err  out  1  qualifies lsu_done: misaligned, illegal funct3, or timeout
lsu_rdata  out  32  extended load data, valid while lsu_done=1
MEM_req  out  1  memory request
MEM_we  out  1  write strobe, valid with MEM_req
MEM_addr  out  ADDR_W  word address
MEM_be  out  4  byte enables
MEM_wDATA  out  32  lane-replicated store data
MEM_gnt  in  1  request accepted this cycle
MEM_rvalid  in  1  read data valid
MEM_rData  in  32  read data word

Behaviour:
- Reset (rset=0, asynchronous): state IDLE. All outputs 0 and all latched fields 0. An in-flight request is dropped immediately (MEM_req falls without waiting for a clock edge).
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - lsu_stall = lsu_valid, combinational.
  - On lsu_valid, latch we, funct3, addr and wdata.
  - Legal and aligned access -> REQ.
  - Otherwise -> DONE with err=1 and no memory access.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
- Illegal funct3: 011, 110, 111; also 100 or 101 with we=1.
- REQ:
  - MEM_req=1. MEM_we, MEM_addr, MEM_be and MEM_wDATA come from latched registers and are held stable until MEM_gnt.
  - MEM_gnt with store -> DONE.
  - MEM_gnt with load -> RESP.
  - The timeout counter increments each cycle without gnt. When count reaches TIMEOUT -> DONE, err=1, MEM_req drops.
- RESP:
  - MEM_req=0. The counter is cleared on entry.
  - MEM_rvalid -> latch the extended data, go to DONE. rvalid arriving in the gnt cycle is ignored; response data is expected no earlier than one cycle after gnt.
  - Timeout in RESP behaves as in REQ.
- DONE:
  - lsu_done=1, lsu_stall=0, lsu_err as decided, lsu_rdata valid (0 on err or store).
  - lsu_valid is ignored this cycle. Next state is IDLE.
- lsu_stall is 1 throughout REQ and RESP.
- Latency: minimum store is 3 cycles (IDLE, REQ with gnt, DONE). Minimum load is 4 cycles.
- Byte enables, with off = addr[1:0]:
  - B: 0001<<off
  - H: 0011<<off
  - W: 1111
- Store data: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}, W -> wdata.
- Load extract: select the byte or half lane at off. B/H sign-extend; BU/HU zero-extend; W passes through.
- Timeout with TIMEOUT=0: never times out.

Decomposition:
- Package riscv_lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, BE_* masks.
- One combinational sub-module, lsu_align. Inputs: funct3, off, wdata, rdata. Outputs: be, wdata_rep, rdata_ext, misalign, illegal.
- riscv_lsu holds the FSM, the latches and the counter.

Test Plan:
- SW addr=0x0000_0010, wdata=0xDEADBEEF, gnt in the first REQ cycle -> MEM_addr=0x04, MEM_be=1111, MEM_wDATA=0xDEADBEEF, MEM_we=1; lsu_done in cycle 3, lsu_err=0.
- SB addr=0x13, wdata=0x000000A5 -> MEM_be=1000, MEM_wDATA=0xA5A5A5A5, MEM_addr=0x04.
- LB and LBU at addr=0x11, MEM_rData=0x0000_8000 (byte1=0x80) -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080; LH at addr 0x12 with MEM_rData=0x8001_0000 -> 0xFFFF8001.
- LW at addr=0x06 -> no MEM_req; DONE the next cycle with lsu_err=1 and rdata=0. funct3=111 behaves the same.
- Load where gnt is held low for 15 cycles -> MEM_req drops and lsu_done=1 with lsu_err=1; a later rvalid in IDLE is ignored.
- Assert rset low during RESP -> all outputs 0 asynchronously. After release, a new SW completes normally.
